// File: rtl/pc_gen.sv
// pc_gen: next-fetch-PC generator sitting in front of the instruction fetch unit.
// Offers either the sequential PC (current fetch PC + INST_BYTES) or a captured
// trap/branch redirect target on a valid/ready stream. It holds invalidate high
// while a redirect is pending so that wrong-path IF/ID contents get discarded.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  BOOT  | first cycle after reset; fetch unit is fetching RESET_VECTOR
//  RUN   | offering sequential PC
//  PEND  | redirect target captured, waiting for the fetch unit to take it
//  HALT  | fetch_en low, nothing offered
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INST_BYTES   = 4
) (
    input  logic            clk,
    input  logic            rst,
    // next fetch PC stream (master)
    output logic [XLEN-1:0] o_next_pc_tdata,
    output logic            o_next_pc_tvalid,
    input  logic            i_next_pc_tready,
    // PC currently held by the fetch unit (slave, always ready)
    input  logic [XLEN-1:0] i_current_pc_tdata,
    input  logic            i_current_pc_tvalid,
    output logic            o_current_pc_tready,
    // redirect sources
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_trap_valid,
    input  logic [XLEN-1:0] i_trap_pc,
    // fetch gating and IF/ID flush
    input  logic            i_fetch_en,
    output logic            o_invalidate
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_d;
    logic [XLEN-1:0] r_tgt;
    logic [XLEN-1:0] w_seq_pc;
    logic [XLEN-1:0] w_redirect_tgt;
    logic            w_redirect;
    logic            w_tvalid;
    logic            w_handshake;

    // The fetch unit launches RESET_VECTOR on its own and always presents its
    // PC, so neither the reset vector value nor the current-PC valid is used here.
    logic            w_unused;
    assign w_unused = ^{i_current_pc_tvalid, i_trap_pc[1:0], i_redirect_pc[1:0],
                        RESET_VECTOR[1:0]};

    assign w_redirect     = i_trap_valid | i_redirect_valid;
    // Trap wins over a same-cycle branch redirect; targets are word aligned.
    assign w_redirect_tgt = i_trap_valid ? {i_trap_pc[XLEN-1:2], 2'b00}
                                         : {i_redirect_pc[XLEN-1:2], 2'b00};
    // Wraps modulo 2^XLEN.
    assign w_seq_pc       = i_current_pc_tdata + XLEN'(INST_BYTES);
    assign w_handshake    = w_tvalid & i_next_pc_tready;

    assign o_next_pc_tdata     = (r_state == PEND) ? r_tgt : w_seq_pc;
    assign o_next_pc_tvalid    = w_tvalid;
    assign o_invalidate        = (r_state == PEND);
    assign o_current_pc_tready = 1'b1;

    // State register and redirect target capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT;
            r_tgt   <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_redirect) begin
                r_tgt <= w_redirect_tgt;
            end
        end
    end

    // Next-state and tvalid; a redirect cycle never hands over a PC.
    always_comb begin
        w_state_d = r_state;
        w_tvalid  = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_d = RUN;
            end
            RUN: begin
                w_tvalid = 1'b1;
                if (!i_fetch_en) begin
                    w_state_d = HALT;
                end
            end
            PEND: begin
                w_tvalid = i_fetch_en;
            end
            HALT: begin
                if (i_fetch_en) begin
                    w_state_d = RUN;
                end
            end
            default: begin
                w_state_d = BOOT;
            end
        endcase
        if (w_redirect) begin
            w_tvalid  = 1'b0;
            w_state_d = PEND;
        end else if (r_state == PEND && w_handshake) begin
            w_state_d = RUN;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with a fetch-unit model and a handshake scoreboard.
module tb_pc_gen;

    localparam int          XLEN = 32;
    localparam logic [31:0] RV   = 32'h0000_1000;

    typedef struct packed {
        logic [31:0] pc;
        logic        inv;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] next_tdata;
    logic        next_tvalid;
    logic        next_tready;
    logic [31:0] cur_pc;
    logic        cur_tready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic        fetch_en;
    logic        invalidate;

    logic        ld_en;
    logic [31:0] ld_pc;

    exp_t        sb_q[$];
    int          n_checks;
    int          n_fail;

    pc_gen #(
        .XLEN        (XLEN),
        .RESET_VECTOR(RV),
        .INST_BYTES  (4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .o_next_pc_tdata    (next_tdata),
        .o_next_pc_tvalid   (next_tvalid),
        .i_next_pc_tready   (next_tready),
        .i_current_pc_tdata (cur_pc),
        .i_current_pc_tvalid(1'b1),
        .o_current_pc_tready(cur_tready),
        .i_redirect_valid   (redirect_valid),
        .i_redirect_pc      (redirect_pc),
        .i_trap_valid       (trap_valid),
        .i_trap_pc          (trap_pc),
        .i_fetch_en         (fetch_en),
        .o_invalidate       (invalidate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fetch unit: restarts at the reset vector, follows accepted PCs, can be preloaded.
    always @(posedge clk) begin
        if (rst)                            cur_pc <= RV;
        else if (ld_en)                     cur_pc <= ld_pc;
        else if (next_tvalid && next_tready) cur_pc <= next_tdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic inv);
        exp_t e;
        e.pc  = pc;
        e.inv = inv;
        sb_q.push_back(e);
    endtask

    // Monitor: every accepted PC must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && next_tvalid === 1'b1 && next_tready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_handshake", next_tdata, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("hs_tdata", next_tdata, e.pc);
                chk("hs_invalidate", {31'd0, invalidate}, {31'd0, e.inv});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        next_tready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        trap_valid     = 1'b0;
        trap_pc        = '0;
        fetch_en       = 1'b1;
        ld_en          = 1'b0;
        ld_pc          = '0;
        repeat (2) tick();

        // BOOT
        rst = 1'b0;
        #1;
        chk("boot_tvalid", {31'd0, next_tvalid}, 32'd0);
        chk("boot_invalidate", {31'd0, invalidate}, 32'd0);
        chk("cur_tready", {31'd0, cur_tready}, 32'd1);
        tick();

        // sequential fetch from the reset vector
        push(32'h1004, 1'b0); tick();
        push(32'h1008, 1'b0); tick();
        push(32'h100C, 1'b0); tick();

        // stall: tdata held while not accepted
        next_tready = 1'b0;
        #1;
        chk("stall_tvalid", {31'd0, next_tvalid}, 32'd1);
        chk("stall_tdata", next_tdata, 32'h1010);
        tick();
        chk("stall_tdata_hold", next_tdata, 32'h1010);
        ld_en = 1'b1;
        ld_pc = 32'hFFFF_FFFC;
        tick();

        // wrap
        ld_en = 1'b0;
        next_tready = 1'b1;
        #1;
        chk("wrap_tdata", next_tdata, 32'h0000_0000);
        push(32'h0000_0000, 1'b0);
        tick();

        // branch redirect, unaligned target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2003;
        #1;
        chk("redir_cycle_tvalid", {31'd0, next_tvalid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("redir_invalidate", {31'd0, invalidate}, 32'd1);
        chk("redir_tvalid", {31'd0, next_tvalid}, 32'd1);
        push(32'h2000, 1'b1);
        tick();
        chk("post_redir_invalidate", {31'd0, invalidate}, 32'd0);
        chk("post_redir_seq", next_tdata, 32'h2004);

        // trap and redirect together: trap wins
        trap_valid     = 1'b1;
        trap_pc        = 32'h80;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2000;
        tick();
        trap_valid     = 1'b0;
        redirect_valid = 1'b0;
        next_tready    = 1'b0;
        #1;
        chk("trap_prio_tdata", next_tdata, 32'h80);
        chk("trap_invalidate", {31'd0, invalidate}, 32'd1);
        tick();

        // newer redirect during PEND overwrites the target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000;
        #1;
        chk("pend_redir_tvalid", {31'd0, next_tvalid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("pend_overwrite_tdata", next_tdata, 32'h3000);
        next_tready = 1'b1;
        push(32'h3000, 1'b1);
        tick();

        // fetch_en gating from RUN
        next_tready = 1'b0;
        fetch_en    = 1'b0;
        #1;
        chk("halt_req_tvalid", {31'd0, next_tvalid}, 32'd1);
        tick();
        chk("halt_tvalid", {31'd0, next_tvalid}, 32'd0);
        fetch_en = 1'b1;
        tick();
        chk("resume_tvalid", {31'd0, next_tvalid}, 32'd1);
        chk("resume_tdata", next_tdata, 32'h3004);

        // PEND with fetch_en low keeps the target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4000;
        tick();
        redirect_valid = 1'b0;
        fetch_en       = 1'b0;
        next_tready    = 1'b1;
        #1;
        chk("pend_halt_tvalid", {31'd0, next_tvalid}, 32'd0);
        chk("pend_halt_invalidate", {31'd0, invalidate}, 32'd1);
        tick();
        fetch_en = 1'b1;
        #1;
        chk("pend_resume_tdata", next_tdata, 32'h4000);
        push(32'h4000, 1'b1);
        tick();

        // reset while PEND
        next_tready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2000;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("pre_rst_invalidate", {31'd0, invalidate}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_pend_tvalid", {31'd0, next_tvalid}, 32'd0);
        chk("rst_pend_invalidate", {31'd0, invalidate}, 32'd0);
        next_tready = 1'b1;
        tick();
        chk("rst_restart_tdata", next_tdata, RV + 32'd4);
        push(RV + 32'd4, 1'b0);
        tick();
        next_tready = 1'b0;
        repeat (2) tick();

        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
